// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped instruction cache with blocking line refill
// Lookup is combinational in IDLE; a miss streams WORDS beats from memory, then re-looks up.
module icache_refill_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_addr,
  input  logic        fetch_req,
  input  logic        flush,
  output logic [31:0] ins,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] miss_count
);

  localparam int WW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int LW = 30 - WW;
  localparam int TW = LW - IW;
  localparam logic [WW-1:0] LAST_BEAT = WW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, FILL_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [WW-1:0]     beat_q, beat_d;
  logic [LW-1:0]     miss_line_q, miss_line_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS];

  logic [WW-1:0] pc_word;
  logic [IW-1:0] pc_index;
  logic [TW-1:0] pc_tag;
  logic [IW-1:0] miss_index;
  logic [TW-1:0] miss_tag;
  logic          lookup_hit;
  logic          miss_fire;
  logic          beat_accept;
  logic          last_accept;
  logic          unused_pc_bits;

  assign pc_word        = pc_addr[2 +: WW];
  assign pc_index       = pc_addr[2+WW +: IW];
  assign pc_tag         = pc_addr[31 -: TW];
  assign miss_index     = miss_line_q[IW-1:0];
  assign miss_tag       = miss_line_q[LW-1 -: TW];
  assign unused_pc_bits = ^pc_addr[1:0];

  assign lookup_hit  = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign miss_fire   = (state_q == IDLE) && fetch_req && !flush && !lookup_hit;
  // flush wins over a beat landing in the same cycle
  assign beat_accept = (state_q == REFILL) && mem_ready && !flush;
  assign last_accept = beat_accept && (beat_q == LAST_BEAT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss_fire) state_d = REFILL;
      REFILL:    if (flush) state_d = IDLE;
                 else if (last_accept) state_d = FILL_DONE;
      FILL_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    hit        = (state_q == IDLE) && fetch_req && !flush && lookup_hit;
    ins        = hit ? data_q[pc_index][pc_word] : 32'd0;
    mem_req    = (state_q == REFILL);
    mem_addr   = mem_req ? {miss_line_q, beat_q, 2'b00} : 32'd0;
    miss_count = miss_count_q;
  end

  always_comb begin
    valid_d      = valid_q;
    beat_d       = beat_q;
    miss_line_d  = miss_line_q;
    miss_count_d = miss_count_q;
    if (miss_fire) begin
      miss_line_d = pc_addr[31:2+WW];
      beat_d      = '0;
      if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
    end
    if (beat_accept) beat_d = beat_q + WW'(1);
    if (flush) valid_d = '0;
    else if (last_accept) valid_d[miss_index] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q      <= '0;
      beat_q       <= '0;
      miss_line_q  <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      miss_line_q  <= miss_line_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (beat_accept) data_q[miss_index][beat_q] <= mem_rdata;
    if (last_accept) tag_q[miss_index] <= miss_tag;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_addr;
  logic        fetch_req;
  logic        flush;
  logic [31:0] ins;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] miss_count;
  logic [31:0] rbase;

  int vectors = 0;
  int miscompares = 0;

  icache_refill_ctrl #(.LINES(16), .WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .pc_addr(pc_addr), .fetch_req(fetch_req), .flush(flush),
    .ins(ins), .hit(hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  always_comb mem_rdata = rbase + {30'd0, mem_addr[3:2]};

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Precondition: IDLE cycle with a miss pending and mem_ready=1; ends back in IDLE.
  task automatic refill(input string tag, input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      tick;
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_addr"}, mem_addr, base + 32'(4 * b));
    end
    tick;
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done_hit"}, 32'(hit), 32'd0);
    tick;
  endtask

  initial begin
    RST = 1'b1; pc_addr = '0; fetch_req = 1'b0; flush = 1'b0; mem_ready = 1'b0; rbase = '0;
    #12;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_cnt", 32'(miss_count), 32'd0);
    #1 RST = 1'b0;
    tick;

    // cold miss at 0x104
    fetch_req = 1'b1; pc_addr = 32'h104; mem_ready = 1'b1; rbase = 32'hA0;
    #1 chk("cold_hit0", 32'(hit), 32'd0);
    refill("cold", 32'h100);
    chk("cold_hit", 32'(hit), 32'd1);
    chk("cold_ins", ins, 32'hA1);
    chk("cold_cnt", 32'(miss_count), 32'd1);

    // hit path
    pc_addr = 32'h10C;
    #1 chk("hitp_hit", 32'(hit), 32'd1);
    chk("hitp_ins", ins, 32'hA3);
    tick;
    chk("hitp_req", 32'(mem_req), 32'd0);
    chk("hitp_cnt", 32'(miss_count), 32'd1);

    // conflict on index 0
    pc_addr = 32'h204; rbase = 32'hB0;
    #1 chk("conf_miss", 32'(hit), 32'd0);
    refill("conf", 32'h200);
    chk("conf_ins", ins, 32'hB1);
    pc_addr = 32'h104; rbase = 32'hA0;
    #1 chk("conf_back_miss", 32'(hit), 32'd0);
    refill("back", 32'h100);
    chk("back_ins", ins, 32'hA1);
    chk("back_cnt", 32'(miss_count), 32'd3);

    // memory stall on beat 2
    pc_addr = 32'h308; rbase = 32'hC0;
    tick; chk("stall_b0", mem_addr, 32'h300);
    tick; chk("stall_b1", mem_addr, 32'h304);
    tick; mem_ready = 1'b0;
    #1 chk("stall_w1", mem_addr, 32'h308);
    tick; chk("stall_w2", mem_addr, 32'h308);
    tick; chk("stall_w3", mem_addr, 32'h308);
    tick; mem_ready = 1'b1;
    #1 chk("stall_w4", mem_addr, 32'h308);
    tick; chk("stall_b3", mem_addr, 32'h30C);
    tick; chk("stall_fd", 32'(mem_req), 32'd0);
    tick;
    chk("stall_ins2", ins, 32'hC2);
    pc_addr = 32'h300;
    #1 chk("stall_ins0", ins, 32'hC0);
    pc_addr = 32'h30C;
    #1 chk("stall_ins3", ins, 32'hC3);
    chk("stall_cnt", 32'(miss_count), 32'd4);

    // flush abort during beat 1
    pc_addr = 32'h404; rbase = 32'hD0;
    tick; chk("abort_b0", mem_addr, 32'h400);
    tick; flush = 1'b1;
    #1 chk("abort_b1", mem_addr, 32'h404);
    tick; flush = 1'b0;
    #1 chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_hit", 32'(hit), 32'd0);
    chk("abort_cnt", 32'(miss_count), 32'd5);
    refill("abort_re", 32'h400);
    chk("abort_re_cnt", 32'(miss_count), 32'd6);
    chk("abort_re_ins", ins, 32'hD1);

    // flush in IDLE after a fill
    flush = 1'b1;
    #1 chk("iflush_hit", 32'(hit), 32'd0);
    tick; flush = 1'b0;
    #1 chk("iflush_cnt", 32'(miss_count), 32'd6);
    chk("iflush_miss", 32'(hit), 32'd0);
    refill("iflush_re", 32'h400);
    chk("iflush_re_cnt", 32'(miss_count), 32'd7);

    // saturation: preload near the top, then abort-and-retry misses
    fetch_req = 1'b0;
    force dut.miss_count_q = 16'hFFFD;
    #1 release dut.miss_count_q;
    #1 chk("sat_pre", 32'(miss_count), 32'hFFFD);
    fetch_req = 1'b1; pc_addr = 32'h504; rbase = 32'hE0;
    tick; chk("sat_1", 32'(miss_count), 32'hFFFE);
    flush = 1'b1; tick; flush = 1'b0;
    tick; chk("sat_2", 32'(miss_count), 32'hFFFF);
    flush = 1'b1; tick; flush = 1'b0;
    tick; chk("sat_3", 32'(miss_count), 32'hFFFF);
    tick; tick; tick; tick; tick;
    chk("sat_fill_ins", ins, 32'hE1);

    // asynchronous reset mid-refill
    pc_addr = 32'h604; rbase = 32'hF0;
    tick; tick;
    chk("rmid_addr", mem_addr, 32'h604);
    #2 RST = 1'b1;
    #1 chk("rmid_req", 32'(mem_req), 32'd0);
    chk("rmid_addr0", mem_addr, 32'd0);
    chk("rmid_hit", 32'(hit), 32'd0);
    chk("rmid_ins", ins, 32'd0);
    chk("rmid_cnt", 32'(miss_count), 32'd0);
    tick; RST = 1'b0;
    pc_addr = 32'h504;
    #1 chk("post_rst_miss", 32'(hit), 32'd0);
    tick;
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_cnt", 32'(miss_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
